dma_engine: RTL and testbench
=============================

Name: dma_engine

Overview:
- Word-granular memory-to-memory DMA controller.
- Acts as a bus master on arbiter master port 2 (currently tied off) to copy LEN words from SRC to DST.
- Also acts as a bus slave on a free slave slot (s4): CPU programs its registers through it.
- Raises an interrupt on completion, alongside the timer IRQ.

Parameters:
- LEN_W, 16, width of transfer length/remaining-count register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cs_  in  1  slave chip select from address decoder, active low
- as_  in  1  shared slave address strobe, active low
- rw  in  1  shared slave read/write; 1=`READ, 0=`WRITE
- addr  in  30  shared slave word address; only addr[1:0] decoded
- wr_data  in  32  shared slave write data
- rd_data  out  32  slave read data
- rdy_  out  1  slave ready, active low
- bus_req_  out  1  master bus request, active low
- bus_grnt_  in  1  master bus grant, active low
- bus_addr  out  30  master word address
- bus_as_  out  1  master address strobe, active low
- bus_rw  out  1  master read/write
- bus_wr_data  out  32  master write data
- bus_rd_data  in  32  shared bus read data
- bus_rdy_  in  1  shared bus ready, active low
- irq  out  1  completion interrupt, active high

Behaviour:
- Register map (addr[1:0]):
  - 0 CTRL: bit0 START/BUSY, bit1 IE, bit2 DONE.
    - Write bit0=1 starts a transfer. Reads of bit0 return busy.
    - DONE is write-1-to-clear.
  - 1 SRC: 30-bit word address.
  - 2 DST: 30-bit word address.
  - 3 LEN: LEN_W bits, zero-extended on read. Reads return remaining count.
- Slave access:
  - cs_=0 and as_=0 sampled at edge N -> rdy_=0 and rd_data valid during cycle N+1, for exactly one cycle.
  - rd_data=0 whenever rdy_=1.
  - Writes to SRC/DST/LEN while busy are ignored. START while busy is ignored. IE and DONE-clear always take effect.
- Reset values:
  - rd_data=0, rdy_=1, bus_req_=1, bus_as_=1, bus_rw=`READ, bus_addr=0, bus_wr_data=0, irq=0.
  - All registers 0; FSM in IDLE.
  - Reset mid-transfer aborts at the next edge: bus released, DONE not set.
- FSM states: IDLE, REQ, RD, WR, NEXT.
  - IDLE: on START with LEN!=0 -> REQ, busy=1. On START with LEN=0 -> DONE=1 immediately, stay IDLE.
  - REQ: bus_req_=0; wait bus_grnt_=0 -> RD.
  - RD: bus_as_=0, bus_rw=`READ, bus_addr=SRC. Hold until bus_rdy_=0, then latch bus_rd_data -> WR.
  - WR: bus_as_=0, bus_rw=`WRITE, bus_addr=DST, bus_wr_data=latched word. Hold until bus_rdy_=0 -> NEXT.
  - NEXT: bus_as_=1; SRC+=1, DST+=1 (mod 2^30, wrap silently); LEN-=1.
    - New LEN=0 -> bus_req_=1, DONE=1, busy=0 -> IDLE.
    - Otherwise -> RD, keeping the request asserted.
- bus_req_ stays low from REQ through the final NEXT.
- bus_as_ is high in IDLE, REQ and NEXT, so every word costs a minimum of 5 cycles: RD 2 + WR 2 + NEXT 1, assuming a 1-wait slave.
- bus_rdy_ is ignored unless bus_as_=0 and bus_grnt_=0.
- irq = DONE & IE, registered; updates the cycle after DONE or IE changes.
- Software must not target the DMA's own register window as SRC/DST. Behaviour in that case is not guaranteed.

Optional Feature:
- Macro: DMA_YIELD_EN.
- Defined:
  - NEXT with remaining LEN!=0 deasserts bus_req_ for one cycle, then goes to REQ to re-arbitrate.
  - This lets the CPU's IF/MEM masters interleave between words.
- Undefined: bus is held for the entire transfer as described above.

Test Plan:
- Program SRC=0x100, DST=0x200, LEN=4, CTRL=0x3; grant immediately; memory model 1-wait -> then:
  - 4 read/write pairs at 0x100..0x103 -> 0x200..0x203 with data copied.
  - bus_req_ low for the whole transfer.
  - irq=1 after last NEXT; LEN reads 0.
- Write CTRL=0x1 with LEN=0 -> no bus_req_ ever; DONE reads 1 next access; irq stays 0 (IE=0).
- During busy transfer, write LEN=9 and SRC=0 -> ignored; CTRL bit0 reads 1; original transfer completes. Then write CTRL=0x4 -> DONE=0, irq=0 next cycle.
- Hold bus_grnt_=1 for 10 cycles after START -> bus_as_ stays 1, FSM stays in REQ; grant at cycle 11 -> first RD address=SRC.
- SRC=0x3FFFFFFF, LEN=2 -> second read address 0x00000000 (wrap).
- Assert reset during WR of word 2 of LEN=5 -> next edge: bus_req_=1, bus_as_=1, all registers 0, irq=0.
- With DMA_YIELD_EN, LEN=3 -> bus_req_ high for exactly one cycle between words (2 gaps).

Source files
------------

// File: rtl/dma_engine.sv
// dma_engine: word-granular memory-to-memory DMA controller.
// It is a bus slave with four registers, CTRL, SRC, DST and LEN, selected by addr[1:0].
// It is also a bus master: it copies LEN words from SRC to DST, one read then one write per word.
// It raises irq when the transfer completes, provided IE is set.
// Optional build macro DMA_YIELD_EN: between words the bus request is dropped for one cycle,
// and the engine re-arbitrates so other masters can get the bus.
module dma_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_,
    input  logic             as_,
    input  logic             rw,
    input  logic [29:0]      addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    output logic             rdy_,
    output logic             bus_req_,
    input  logic             bus_grnt_,
    output logic [29:0]      bus_addr,
    output logic             bus_as_,
    output logic             bus_rw,
    output logic [31:0]      bus_wr_data,
    input  logic [31:0]      bus_rd_data,
    input  logic             bus_rdy_,
    output logic             irq
);

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {IDLE, REQ, RD, WR, NEXT} state_t;

    state_t           r_state, w_next;
    logic [29:0]      r_src, r_dst;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_data;
    logic             r_ie, r_done, r_irq;
    logic [31:0]      r_rd_data;
    logic             r_rdy_n;

    logic w_sel, w_wr, w_rd, w_busy, w_start, w_go, w_last, w_bus_ack;

    assign w_sel     = !cs_ && !as_;
    assign w_wr      = w_sel && (rw == WRITE);
    assign w_rd      = w_sel && (rw == READ);
    assign w_busy    = (r_state != IDLE);
    // START is honoured only from idle; a START with LEN=0 just flags DONE
    assign w_start   = w_wr && (addr[1:0] == 2'd0) && wr_data[0] && !w_busy;
    assign w_go      = w_start && (r_len != '0);
    assign w_last    = (r_state == NEXT) && (r_len == LEN_W'(1));
    // slave ready only counts while we own the bus and strobe it
    assign w_bus_ack = !bus_rdy_ && !bus_grnt_;

    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_n;
    assign irq     = r_irq;

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state and bus master outputs, decoded from state
    always_comb begin
        w_next      = r_state;
        bus_req_    = 1'b1;
        bus_as_     = 1'b1;
        bus_rw      = READ;
        bus_addr    = '0;
        bus_wr_data = '0;
        case (r_state)
            IDLE: if (w_go) w_next = REQ;
            REQ: begin
                bus_req_ = 1'b0;
                if (!bus_grnt_) w_next = RD;
            end
            RD: begin
                bus_req_ = 1'b0;
                bus_as_  = 1'b0;
                bus_addr = r_src;
                if (w_bus_ack) w_next = WR;
            end
            WR: begin
                bus_req_    = 1'b0;
                bus_as_     = 1'b0;
                bus_rw      = WRITE;
                bus_addr    = r_dst;
                bus_wr_data = r_data;
                if (w_bus_ack) w_next = NEXT;
            end
            NEXT: begin
`ifdef DMA_YIELD_EN
                // drop the request for this one cycle unless this was the last word
                bus_req_ = !w_last;
                w_next   = w_last ? IDLE : REQ;
`else
                bus_req_ = 1'b0;
                w_next   = w_last ? IDLE : RD;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // register file, slave response, transfer datapath and irq
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_data    <= '0;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
            r_irq     <= 1'b0;
            r_rd_data <= '0;
            r_rdy_n   <= 1'b1;
        end else begin
            r_rdy_n   <= !w_sel;
            r_rd_data <= '0;
            if (w_rd) begin
                case (addr[1:0])
                    2'd0:    r_rd_data <= {29'd0, r_done, r_ie, w_busy};
                    2'd1:    r_rd_data <= {2'b00, r_src};
                    2'd2:    r_rd_data <= {2'b00, r_dst};
                    default: r_rd_data <= 32'(r_len);
                endcase
            end
            if (w_wr) begin
                case (addr[1:0])
                    2'd0: begin
                        r_ie <= wr_data[1];
                        if (wr_data[2])               r_done <= 1'b0;
                        if (w_start && r_len == '0)  r_done <= 1'b1;
                    end
                    2'd1:    if (!w_busy) r_src <= wr_data[29:0];
                    2'd2:    if (!w_busy) r_dst <= wr_data[29:0];
                    default: if (!w_busy) r_len <= wr_data[LEN_W-1:0];
                endcase
            end
            if (r_state == RD && w_bus_ack) r_data <= bus_rd_data;
            if (r_state == NEXT) begin
                r_src <= r_src + 30'd1;
                r_dst <= r_dst + 30'd1;
                r_len <= r_len - LEN_W'(1);
                // completion wins over a same-cycle DONE clear
                if (w_last) r_done <= 1'b1;
            end
            r_irq <= r_done & r_ie;
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed test of dma_engine.
// A one-wait-state memory model is attached to the master port,
// and a CPU task pair drives the slave port.
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [29:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        bus_req_;
    logic        bus_grnt_ = 1'b0;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] m_rd = '0;
    logic        m_rdy_ = 1'b1;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    dma_engine #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .bus_req_(bus_req_),
        .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .bus_rd_data(m_rd), .bus_rdy_(m_rdy_), .irq(irq)
    );

    always #5 clk = ~clk;

    // memory model: one wait state, then ready for a single cycle
    logic [31:0] mem [logic [29:0]];
    logic [29:0] rlog[$];
    logic [29:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    always @(posedge clk) begin
        if (!m_rdy_) m_rdy_ <= 1'b1;
        else if (!bus_as_ && !bus_grnt_) begin
            m_rdy_ <= 1'b0;
            if (bus_rw) begin
                m_rd <= mem.exists(bus_addr) ? mem[bus_addr] : 32'd0;
                rlog.push_back(bus_addr);
            end else begin
                mem[bus_addr] = bus_wr_data;
                wlog_a.push_back(bus_addr);
                wlog_d.push_back(bus_wr_data);
            end
        end
    end

    // bus request monitor: cycles held low and low-to-high transitions
    int lo_cnt = 0, rises = 0;
    logic prev_req = 1'b1;
    always @(negedge clk) begin
        if (!bus_req_) lo_cnt++;
        if (!prev_req && bus_req_) rises++;
        prev_req = bus_req_;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = {28'd0, a}; wr_data = d;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = {28'd0, a};
        @(negedge clk);
        d = (rdy_ === 1'b0) ? rd_data : 32'hDEAD_BEEF;
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    // wait for the request to go low, then to stay high for two cycles
    task automatic wait_done(input string tag);
        bit ok = 0;
        int hi = 0;
        for (int k = 0; k < 400; k++) begin
            if (!bus_req_) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            ok = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (bus_req_) hi++; else hi = 0;
                if (hi >= 2) begin ok = 1; break; end
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

`ifdef DMA_YIELD_EN
    localparam int RISES3 = 3;
    localparam int RISES4 = 4;
`else
    localparam int RISES3 = 1;
    localparam int RISES4 = 1;
`endif

    initial begin
        logic [31:0] d;
        int wb, rb, lo0, ri0;
        bit ok, as_hi;

        repeat (3) @(negedge clk);
        chk("rst_rdy_", 32'(rdy_), 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_bus_req_", 32'(bus_req_), 32'd1);
        chk("rst_bus_as_", 32'(bus_as_), 32'd1);
        chk("rst_bus_rw", 32'(bus_rw), 32'd1);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wr_data", bus_wr_data, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        cpu_read(2'd0, d); chk("rst_ctrl", d, 32'd0);
        cpu_read(2'd3, d); chk("rst_len", d, 32'd0);

        // basic 4-word copy with immediate grant
        for (int i = 0; i < 4; i++) mem[30'h100 + 30'(i)] = 32'hA000_0000 + 32'(i);
        wb = wlog_a.size(); rb = rlog.size(); lo0 = lo_cnt; ri0 = rises;
        cpu_write(2'd1, 32'h100);
        cpu_write(2'd2, 32'h200);
        cpu_write(2'd3, 32'd4);
        cpu_write(2'd0, 32'h3);
        wait_done("t1_done");
        chk("t1_nwr", 32'(wlog_a.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_addr", 32'(rlog[rb + i]), 32'h100 + 32'(i));
            chk("t1_wr_addr", 32'(wlog_a[wb + i]), 32'h200 + 32'(i));
            chk("t1_wr_data", wlog_d[wb + i], 32'hA000_0000 + 32'(i));
        end
        chk("t1_req_lo_cycles", 32'(lo_cnt - lo0), 32'd21);
        chk("t1_req_rises", 32'(rises - ri0), 32'(RISES4));
        chk("t1_irq", 32'(irq), 32'd1);
        cpu_read(2'd3, d); chk("t1_len", d, 32'd0);
        cpu_read(2'd1, d); chk("t1_src", d, 32'h104);
        cpu_read(2'd0, d); chk("t1_ctrl", d, 32'h6);

        // clear DONE, then START with LEN=0
        cpu_write(2'd0, 32'h4);
        cpu_read(2'd0, d); chk("t2_ctrl_clr", d, 32'd0);
        lo0 = lo_cnt;
        cpu_write(2'd0, 32'h1);
        cpu_read(2'd0, d); chk("t2_done", d, 32'h4);
        repeat (4) @(negedge clk);
        chk("t2_no_req", 32'(lo_cnt - lo0), 32'd0);
        chk("t2_irq", 32'(irq), 32'd0);
        cpu_write(2'd0, 32'h4);

        // writes while busy are ignored
        for (int i = 0; i < 4; i++) mem[30'h300 + 30'(i)] = 32'hB000_0000 + 32'(i);
        wb = wlog_a.size();
        cpu_write(2'd1, 32'h300);
        cpu_write(2'd2, 32'h400);
        cpu_write(2'd3, 32'd4);
        cpu_write(2'd0, 32'h3);
        cpu_write(2'd3, 32'd9);
        cpu_write(2'd1, 32'd0);
        cpu_read(2'd0, d); chk("t3_busy", d & 32'h1, 32'd1);
        wait_done("t3_done");
        chk("t3_nwr", 32'(wlog_a.size() - wb), 32'd4);
        chk("t3_last_data", mem[30'h403], 32'hB000_0003);
        cpu_read(2'd3, d); chk("t3_len", d, 32'd0);
        cpu_read(2'd1, d); chk("t3_src", d, 32'h304);
        chk("t3_irq_set", 32'(irq), 32'd1);
        cpu_write(2'd0, 32'h4);
        @(negedge clk);
        chk("t3_irq_clr", 32'(irq), 32'd0);
        cpu_read(2'd0, d); chk("t3_ctrl_clr", d, 32'd0);

        // grant withheld for 10 cycles
        mem[30'h500] = 32'h5555_AAAA;
        bus_grnt_ = 1'b1;
        cpu_write(2'd1, 32'h500);
        cpu_write(2'd2, 32'h600);
        cpu_write(2'd3, 32'd1);
        cpu_write(2'd0, 32'h1);
        as_hi = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!bus_as_ || bus_req_) as_hi = 1'b0;
            @(negedge clk);
        end
        chk("t4_held_in_req", 32'(as_hi), 32'd1);
        bus_grnt_ = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus_as_) begin ok = 1; break; end
        end
        chk("t4_as_seen", 32'(ok), 32'd1);
        chk("t4_rd_addr", 32'(bus_addr), 32'h500);
        chk("t4_rd_rw", 32'(bus_rw), 32'd1);
        wait_done("t4_done");
        chk("t4_copy", mem[30'h600], 32'h5555_AAAA);
        cpu_write(2'd0, 32'h4);

        // source address wraps
        mem[30'h3FFF_FFFF] = 32'h0000_0011;
        mem[30'h0] = 32'h0000_0022;
        rb = rlog.size();
        cpu_write(2'd1, 32'h3FFF_FFFF);
        cpu_write(2'd2, 32'h700);
        cpu_write(2'd3, 32'd2);
        cpu_write(2'd0, 32'h1);
        wait_done("t5_done");
        chk("t5_rd0", 32'(rlog[rb]), 32'h3FFF_FFFF);
        chk("t5_rd1_wrap", 32'(rlog[rb + 1]), 32'd0);
        chk("t5_copy1", mem[30'h701], 32'h22);
        cpu_read(2'd1, d); chk("t5_src", d, 32'd1);
        cpu_write(2'd0, 32'h4);

        // 3-word run; yield build drops request once between words
        for (int i = 0; i < 3; i++) mem[30'hA00 + 30'(i)] = 32'hC000_0000 + 32'(i);
        lo0 = lo_cnt; ri0 = rises;
        cpu_write(2'd1, 32'hA00);
        cpu_write(2'd2, 32'hB00);
        cpu_write(2'd3, 32'd3);
        cpu_write(2'd0, 32'h1);
        wait_done("t6_done");
        chk("t6_req_rises", 32'(rises - ri0), 32'(RISES3));
        chk("t6_req_lo_cycles", 32'(lo_cnt - lo0), 32'd16);
        chk("t6_copy2", mem[30'hB02], 32'hC000_0002);
        cpu_write(2'd0, 32'h4);

        // reset during the write of word 2
        wb = wlog_a.size();
        cpu_write(2'd1, 32'h800);
        cpu_write(2'd2, 32'h900);
        cpu_write(2'd3, 32'd5);
        cpu_write(2'd0, 32'h3);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus_as_ && bus_rw == 1'b0 && wlog_a.size() == wb + 1) begin ok = 1; break; end
        end
        chk("t7_reached_wr2", 32'(ok), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_req_", 32'(bus_req_), 32'd1);
        chk("t7_as_", 32'(bus_as_), 32'd1);
        chk("t7_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        cpu_read(2'd0, d); chk("t7_ctrl", d, 32'd0);
        cpu_read(2'd1, d); chk("t7_src", d, 32'd0);
        cpu_read(2'd2, d); chk("t7_dst", d, 32'd0);
        cpu_read(2'd3, d); chk("t7_len", d, 32'd0);
        repeat (3) @(negedge clk);
        chk("t7_idle_req_", 32'(bus_req_), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
